// File: rtl/gen_key_unit_if.sv
// Key bus between the key source and the AES-128 key expansion unit.
// data_out[10-r] carries round key r, so data_out[10] is the cipher key itself.
interface gen_key_unit_if;
    logic [127:0] data_in;
    logic [127:0] data_out [10:0];

    modport master (output data_in, input data_out);
    modport slave  (input data_in, output data_out);
endinterface

// File: rtl/gen_key_unit.sv
// AES-128 key expansion: all 11 round keys computed combinationally from the
// key, registered on every rising edge (1-cycle latency, no enable).
module gen_key_unit (
    input  logic           clk,
    input  logic           n_rst,
    gen_key_unit_if.slave  bus
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input int unsigned r);
        case (r)
            1:       return 8'h01;
            2:       return 8'h02;
            3:       return 8'h04;
            4:       return 8'h08;
            5:       return 8'h10;
            6:       return 8'h20;
            7:       return 8'h40;
            8:       return 8'h80;
            9:       return 8'h1b;
            10:      return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [31:0] w [44];
    logic [31:0] temp;

    // Loop is fully unrolled: each i%4==0 step gets its own four S-box lookups.
    always_comb begin
        w    = '{default: '0};
        temp = '0;
        w[0] = bus.data_in[127:96];
        w[1] = bus.data_in[95:64];
        w[2] = bus.data_in[63:32];
        w[3] = bus.data_in[31:0];
        for (int unsigned i = 4; i < 44; i++) begin
            temp = w[i-1];
            if ((i % 4) == 0)
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon(i / 4), 24'h0};
            w[i] = w[i-4] ^ temp;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int unsigned r = 0; r < 11; r++)
                bus.data_out[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < 11; r++)
                bus.data_out[10-r] <= {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    end

endmodule

// File: tb/tb_gen_key_unit.sv
// Scoreboard bench for gen_key_unit: expectations are queued when a key is
// driven and checked one rising edge later against published key schedules.
module tb_gen_key_unit;

    logic clk = 1'b0;
    logic n_rst;
    gen_key_unit_if bus ();

    gen_key_unit gen_key (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_AFAD = 128'hAFADB59705579CCE9FD3644F45E3008B;
    localparam logic [127:0] K_ZERO = 128'h0;
    localparam logic [127:0] K_61CD = 128'h61cd359550d93d14487441a0ad6624c8;

    typedef struct {
        int unsigned  due;
        int unsigned  idx;
        logic [127:0] exp;
        string        tag;
    } exp_t;

    exp_t        sb [$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int unsigned idx, input logic [127:0] exp);
        exp_t e;
        e.due = cyc + 1;
        e.idx = idx;
        e.exp = exp;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Drive a key (called at a falling edge) and queue what the next edge must show.
    task automatic push_key(input string tag, input logic [127:0] key);
        bus.data_in = key;
        expect_out({tag, "[10]"}, 10, key);
        if (key == K_FIPS) begin
            expect_out({tag, "[9]"}, 9, 128'ha0fafe1788542cb123a339392a6c7605);
            expect_out({tag, "[0]"}, 0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        end else if (key == K_AFAD) begin
            expect_out({tag, "[9]"}, 9, 128'hBFCE88F9BA991437254A707860A970F3);
            expect_out({tag, "[8]"}, 8, 128'h6E9F8529D406911EF14CE16691E59195);
            expect_out({tag, "[7]"}, 7, 128'hB31EAFA867183EB69654DFD007B14E45);
            expect_out({tag, "[6]"}, 6, 128'h7331C16D1429FFDB827D200B85CC6E4E);
            expect_out({tag, "[2]"}, 2, 128'hDA3EB0AF430C540355223DBCF7268674);
            expect_out({tag, "[0]"}, 0, 128'h40C7DCC935B1AA0D15E5E175C2972C79);
        end else if (key == K_ZERO) begin
            expect_out({tag, "[9]"}, 9, 128'h62636363626363636263636362636363);
            expect_out({tag, "[0]"}, 0, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 11; i++)
            check_eq($sformatf("%s[%0d]", tag, i), bus.data_out[i], '0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check_eq(e.tag, bus.data_out[e.idx], e.exp);
            end
        end
    end

    initial begin : stim
        logic [127:0] rk;
        n_rst       = 1'b0;
        bus.data_in = K_FIPS;
        repeat (3) @(negedge clk);
        check_all_zero("rst_hold");

        @(negedge clk);
        n_rst = 1'b1;
        push_key("fips", K_FIPS);
        @(negedge clk) push_key("afad", K_AFAD);
        @(negedge clk) push_key("zero", K_ZERO);
        @(negedge clk) push_key("b2b_fips", K_FIPS);
        @(negedge clk) push_key("b2b_61cd", K_61CD);
        for (int i = 0; i < 6; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk) push_key($sformatf("rand%0d", i), rk);
        end

        // Mid-cycle changes to data_in must not disturb the registered keys.
        @(negedge clk) push_key("hold", K_AFAD);
        @(posedge clk);
        #3 bus.data_in = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        check_eq("hold_between[10]", bus.data_out[10], K_AFAD);
        check_eq("hold_between[9]", bus.data_out[9], 128'hBFCE88F9BA991437254A707860A970F3);
        rk = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
        push_key("pre_rst", rk);
        repeat (2) @(negedge clk);

        // Asynchronous reset between edges clears outputs without a clock edge.
        #2 n_rst = 1'b0;
        #1 check_all_zero("async_rst");
        bus.data_in = K_AFAD;
        repeat (2) @(negedge clk);
        check_all_zero("rst_hold2");

        n_rst = 1'b1;
        push_key("post_rst", K_61CD);
        repeat (2) @(negedge clk);
        check_eq("sb_drained", 128'(sb.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
